fp_add_normalizer: RTL and testbench

- Stage directly downstream of the alignment stage in the FP adder.
- Consumes the two aligned 24-bit mantissas (hidden bit included), the operand signs and the common exponent.
- Performs the signed mantissa add/subtract and iterative normalization.
- Packs the IEEE-754 single-precision sum (truncation, no rounding) behind a valid/ready handshake.

---
 rtl/fp_add_normalizer_if.sv | 37 +++
 rtl/fp_add_normalizer.sv | 141 ++++++++++++++
 tb/tb_fp_add_normalizer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fp_add_normalizer_if.sv
// Handshake bundle between the FP alignment stage, the add/normalize stage
// and its consumer: aligned operands in, packed single-precision sum out.
//   in_valid/in_ready   : operand handshake (driven by aligner / stage)
//   signA/signB         : operand signs
//   alignedMantissaA/B  : aligned mantissas, hidden bit included
//   exponentOut         : common exponent produced by alignment
//   out_valid/out_ready : result handshake (stage / consumer)
//   result              : packed {sign, exponent, fraction}
interface fp_add_normalizer_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    signA;
  logic                    signB;
  logic [MANT_W-1:0]       alignedMantissaA;
  logic [MANT_W-1:0]       alignedMantissaB;
  logic [EXP_W-1:0]        exponentOut;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+MANT_W-1:0] result;

  modport slave (
    input  in_valid, signA, signB,
    input  alignedMantissaA, alignedMantissaB,
    input  exponentOut, out_ready,
    output in_ready, out_valid, result
  );

  modport master (
    output in_valid, signA, signB,
    output alignedMantissaA, alignedMantissaB,
    output exponentOut, out_ready,
    input  in_ready, out_valid, result
  );
endinterface

// File: rtl/fp_add_normalizer.sv
// FP adder add/normalize stage: signed mantissa add, iterative
// normalization (one left shift per cycle) and truncating pack.
//   clk   : rising-edge clock
//   reset : asynchronous active-high, aborts any operation in flight
//   bus   : slave side of fp_add_normalizer_if (operands in, result out)
module fp_add_normalizer #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  fp_add_normalizer_if.slave  bus
);

  localparam int RES_W = EXP_W + MANT_W;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  typedef enum logic [1:0] {
    IDLE, ADD, NORM, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [MANT_W-1:0] ma_q, ma_d;
  logic [MANT_W-1:0] mb_q, mb_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [RES_W-1:0]  result_q, result_d;

  logic [MANT_W:0]   sum;
  logic              sgn;
  logic [EXP_W-1:0]  exp_inc;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    sum      = '0;
    sgn      = sa_q;
    exp_inc  = exp_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sa_d    = bus.signA;
          sb_d    = bus.signB;
          ma_d    = bus.alignedMantissaA;
          mb_d    = bus.alignedMantissaB;
          exp_d   = bus.exponentOut;
          state_d = ADD;
        end
      end
      ADD: begin
        // Magnitude subtract keeps the sum non-negative; equal
        // magnitudes cancel to zero and pack as +0 in NORM.
        if (sa_q == sb_q) begin
          sum = {1'b0, ma_q} + {1'b0, mb_q};
        end else if (ma_q >= mb_q) begin
          sum = {1'b0, ma_q - mb_q};
        end else begin
          sum = {1'b0, mb_q - ma_q};
          sgn = sb_q;
        end
        sign_d = sgn;
        if (exp_q == EXP_MAX) begin
          result_d = {sa_q, EXP_MAX, {(MANT_W-1){1'b0}}};
          state_d  = DONE;
        end else if (sum[MANT_W]) begin
          mant_d = sum[MANT_W:1];
          exp_d  = exp_inc;
          if (exp_inc == EXP_MAX) begin
            result_d = {sgn, EXP_MAX, {(MANT_W-1){1'b0}}};
            state_d  = DONE;
          end else begin
            state_d = NORM;
          end
        end else begin
          mant_d  = sum[MANT_W-1:0];
          state_d = NORM;
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          result_d = '0;
          state_d  = DONE;
        end else if (mant_q[MANT_W-1]) begin
          result_d = {sign_q, exp_q, mant_q[MANT_W-2:0]};
          state_d  = DONE;
        end else if (exp_q > EXP_ONE) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 1'b1;
        end else begin
          // Out of exponent range: emit as denormal.
          result_d = {sign_q, {EXP_W{1'b0}}, mant_q[MANT_W-2:0]};
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      mant_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Directed-vector bench for fp_add_normalizer.
// Latency is counted in clock edges starting with the accept edge as 1.
module tb_fp_add_normalizer;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fp_add_normalizer_if bus ();

  fp_add_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    bus.signA            = 1'($urandom);
    bus.signB            = 1'($urandom);
    bus.alignedMantissaA = 24'($urandom);
    bus.alignedMantissaB = 24'($urandom);
    bus.exponentOut      = 8'($urandom);
  endtask

  // Present operands, accept, then wait (bounded) for out_valid.
  task automatic start_op(input logic sa, input logic sb,
                          input logic [23:0] ma, input logic [23:0] mb,
                          input logic [7:0] e, output int lat);
    @(negedge clk);
    bus.signA            = sa;
    bus.signB            = sb;
    bus.alignedMantissaA = ma;
    bus.alignedMantissaB = mb;
    bus.exponentOut      = e;
    bus.in_valid         = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic sa, input logic sb,
                        input logic [23:0] ma, input logic [23:0] mb,
                        input logic [7:0] e, input logic [31:0] exp_res,
                        input int exp_lat);
    int lat;
    bus.out_ready = 1'b1;
    chk({tag, ".rdy0"}, 32'(bus.in_ready), 32'd1);
    start_op(sa, sb, ma, mb, e, lat);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".res"}, bus.result, exp_res);
    chk({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, ".vld1"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".rdy1"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scramble();
    reset = 1'b1;
    #1;
    chk("rst.rdy", 32'(bus.in_ready), 32'd1);
    chk("rst.vld", 32'(bus.out_valid), 32'd0);
    chk("rst.res", bus.result, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op("one_plus_one", 0, 0, 24'h800000, 24'h800000, 8'h7F,
           32'h40000000, 3);
    run_op("sub_a_big", 0, 1, 24'hC00000, 24'h800000, 8'h7F,
           32'h3F000000, 4);
    run_op("sub_b_big", 0, 1, 24'h800000, 24'hC00000, 8'h7F,
           32'hBF000000, 4);
    run_op("cancel", 0, 1, 24'h800000, 24'h800000, 8'h7F,
           32'h00000000, 3);
    run_op("denorm", 0, 1, 24'h800000, 24'h400000, 8'h01,
           32'h00400000, 3);
    run_op("denorm2", 0, 1, 24'h800000, 24'h700000, 8'h03,
           32'h00400000, 5);
    run_op("overflow", 1, 1, 24'h800000, 24'h800000, 8'hFE,
           32'hFF800000, 2);
    run_op("exp_inf", 1, 0, 24'h123456, 24'h000001, 8'hFF,
           32'hFF800000, 2);
    run_op("shift23", 0, 1, 24'h800001, 24'h800000, 8'h7F,
           32'h34000000, 26);

    // Backpressure: result held while consumer stalls.
    bus.out_ready = 1'b0;
    start_op(0, 0, 24'h800000, 24'h800000, 8'h7F, lat);
    chk("bp.lat", 32'(lat), 32'd3);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp.vld%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp.res%0d", i), bus.result, 32'h40000000);
      chk($sformatf("bp.rdy%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.vld_end", 32'(bus.out_valid), 32'd0);
    chk("bp.rdy_end", 32'(bus.in_ready), 32'd1);

    // Reset in the NORM cycle of 1.5-1.0.
    @(negedge clk);
    bus.signA            = 1'b0;
    bus.signB            = 1'b1;
    bus.alignedMantissaA = 24'hC00000;
    bus.alignedMantissaB = 24'h800000;
    bus.exponentOut      = 8'h7F;
    bus.in_valid         = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst.vld", 32'(bus.out_valid), 32'd0);
    chk("mid_rst.rdy", 32'(bus.in_ready), 32'd1);
    chk("mid_rst.res", bus.result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst.novld", 32'(bus.out_valid), 32'd0);
    run_op("after_rst", 0, 1, 24'hC00000, 24'h800000, 8'h7F,
           32'h3F000000, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
